// File: rtl/game_if.sv
// Game controller signal bundle.
//   tick                    : one-clk pulse per frame
//   bDer, bIzq, bCen, bR    : right, left, fire, restart buttons (asynchronous, active-high)
//   airplane_x, gun_x       : left edge of airplane and gun
//   bullet_x, bullet_y      : bullet position; bullet_active marks a drawn bullet
//   col, finish, score      : HIT indicator, OVER indicator, hit count
// master drives frame/buttons and observes the game; slave is the controller.
interface game_if;
  logic       tick;
  logic       bDer;
  logic       bIzq;
  logic       bCen;
  logic       bR;
  logic [9:0] airplane_x;
  logic [9:0] gun_x;
  logic [9:0] bullet_x;
  logic [9:0] bullet_y;
  logic       bullet_active;
  logic       col;
  logic       finish;
  logic [4:0] score;

  modport master (
    output tick, bDer, bIzq, bCen, bR,
    input  airplane_x, gun_x, bullet_x, bullet_y, bullet_active, col, finish, score
  );

  modport slave (
    input  tick, bDer, bIzq, bCen, bR,
    output airplane_x, gun_x, bullet_x, bullet_y, bullet_active, col, finish, score
  );
endinterface

// File: rtl/game_ctrl.sv
// Shooting-game controller: a gun at the bottom fires a bullet upward at an airplane that
// bounces horizontally near the top of the screen. All motion advances on the frame tick.
// Ports:
//   clk   : pixel clock, all state on rising edge
//   reset : asynchronous active-low reset
//   gif   : game_if.slave -- tick and buttons in; positions, bullet, col, finish, score out
module game_ctrl #(
  parameter int unsigned SCREEN_W    = 640,
  parameter int unsigned PLANE_W     = 32,
  parameter int unsigned PLANE_H     = 16,
  parameter int unsigned PLANE_Y     = 40,
  parameter int unsigned GUN_W       = 16,
  parameter int unsigned GUN_Y       = 440,
  parameter int unsigned GUN_STEP    = 4,
  parameter int unsigned PLANE_STEP  = 2,
  parameter int unsigned BULLET_STEP = 8,
  parameter int unsigned WIN_SCORE   = 10,
  parameter int unsigned HIT_TICKS   = 30
) (
  input logic   clk,
  input logic   reset,
  game_if.slave gif
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StPlay = 2'd1;
  localparam logic [1:0] StHit  = 2'd2;
  localparam logic [1:0] StOver = 2'd3;

  localparam int unsigned HcW = $clog2(HIT_TICKS + 1);

  localparam logic [9:0]  GunRst   = 10'(SCREEN_W / 2 - GUN_W / 2);
  localparam logic [10:0] GunMax   = 11'(SCREEN_W - GUN_W);
  localparam logic [10:0] PlaneMax = 11'(SCREEN_W - PLANE_W);
  localparam logic [10:0] PlaneTop = 11'(PLANE_Y);
  localparam logic [10:0] PlaneBot = 11'(PLANE_Y + PLANE_H);

  // Synchronizers, bit order {bR, bCen, bIzq, bDer}
  logic [3:0] sync1_q, sync2_q;
  logic       cen_prev_q, r_prev_q;
  logic       der, izq, cen_edge, r_edge;

  logic [1:0]     state_q, state_d;
  logic [9:0]     plane_x_q, plane_x_d;
  logic           dir_right_q, dir_right_d;
  logic [9:0]     gun_x_q, gun_x_d;
  logic [9:0]     bullet_x_q, bullet_x_d;
  logic [9:0]     bullet_y_q, bullet_y_d;
  logic           bullet_act_q, bullet_act_d;
  logic           fire_pend_q, fire_pend_d;
  logic [4:0]     score_q, score_d;
  logic [HcW-1:0] hit_cnt_q, hit_cnt_d;

  logic [10:0] gun_up, plane_up, plane_far;
  logic        hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      cen_prev_q <= 1'b0;
      r_prev_q   <= 1'b0;
    end else begin
      sync1_q    <= {gif.bR, gif.bCen, gif.bIzq, gif.bDer};
      sync2_q    <= sync1_q;
      cen_prev_q <= sync2_q[2];
      r_prev_q   <= sync2_q[3];
    end
  end

  assign der      = sync2_q[0];
  assign izq      = sync2_q[1];
  assign cen_edge = sync2_q[2] & ~cen_prev_q;
  assign r_edge   = sync2_q[3] & ~r_prev_q;

  assign gun_up    = {1'b0, gun_x_q} + 11'(GUN_STEP);
  assign plane_up  = {1'b0, plane_x_q} + 11'(PLANE_STEP);
  assign plane_far = {1'b0, plane_x_q} + 11'(PLANE_W);

  // Hit test on the registered positions, before this tick's motion
  assign hit = bullet_act_q &&
               ({1'b0, bullet_x_q} >= {1'b0, plane_x_q}) && ({1'b0, bullet_x_q} < plane_far) &&
               ({1'b0, bullet_y_q} >= PlaneTop) && ({1'b0, bullet_y_q} < PlaneBot);

  always_comb begin
    state_d      = state_q;
    plane_x_d    = plane_x_q;
    dir_right_d  = dir_right_q;
    gun_x_d      = gun_x_q;
    bullet_x_d   = bullet_x_q;
    bullet_y_d   = bullet_y_q;
    bullet_act_d = bullet_act_q;
    fire_pend_d  = fire_pend_q;
    score_d      = score_q;
    hit_cnt_d    = hit_cnt_q;

    if (r_edge) begin
      state_d      = StIdle;
      plane_x_d    = '0;
      dir_right_d  = 1'b1;
      gun_x_d      = GunRst;
      bullet_x_d   = '0;
      bullet_y_d   = 10'(GUN_Y);
      bullet_act_d = 1'b0;
      fire_pend_d  = 1'b0;
      score_d      = '0;
      hit_cnt_d    = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cen_edge) state_d = StPlay;
        end
        StPlay: begin
          if (gif.tick) begin
            if (der && !izq) begin
              gun_x_d = (gun_up > GunMax) ? GunMax[9:0] : gun_up[9:0];
            end else if (izq && !der) begin
              gun_x_d = (gun_x_q < 10'(GUN_STEP)) ? '0 : gun_x_q - 10'(GUN_STEP);
            end

            if (hit) begin
              bullet_act_d = 1'b0;
              score_d      = (score_q == 5'd31) ? score_q : score_q + 5'd1;
              hit_cnt_d    = '0;
              state_d      = StHit;
            end else begin
              if (bullet_act_q) begin
                if (bullet_y_q < 10'(BULLET_STEP)) bullet_act_d = 1'b0;
                else                               bullet_y_d   = bullet_y_q - 10'(BULLET_STEP);
              end
              // Reaching either limit clamps there and reverses on the same tick
              if (dir_right_q) begin
                if (plane_up >= PlaneMax) begin
                  plane_x_d   = PlaneMax[9:0];
                  dir_right_d = 1'b0;
                end else begin
                  plane_x_d = plane_up[9:0];
                end
              end else if (plane_x_q <= 10'(PLANE_STEP)) begin
                plane_x_d   = '0;
                dir_right_d = 1'b1;
              end else begin
                plane_x_d = plane_x_q - 10'(PLANE_STEP);
              end
            end

            // Spawn uses the pre-move gun position; a live bullet swallows the request
            if (fire_pend_q) begin
              fire_pend_d = 1'b0;
              if (!bullet_act_q) begin
                bullet_x_d   = gun_x_q + 10'(GUN_W / 2);
                bullet_y_d   = 10'(GUN_Y);
                bullet_act_d = 1'b1;
              end
            end
          end
          // An edge coinciding with a tick is held for the following tick
          if (cen_edge) fire_pend_d = 1'b1;
        end
        StHit: begin
          if (gif.tick) begin
            if (hit_cnt_q == HcW'(HIT_TICKS - 1)) begin
              hit_cnt_d = '0;
              state_d   = (score_q >= 5'(WIN_SCORE)) ? StOver : StPlay;
            end else begin
              hit_cnt_d = hit_cnt_q + HcW'(1);
            end
          end
        end
        StOver: ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      plane_x_q    <= '0;
      dir_right_q  <= 1'b1;
      gun_x_q      <= GunRst;
      bullet_x_q   <= '0;
      bullet_y_q   <= 10'(GUN_Y);
      bullet_act_q <= 1'b0;
      fire_pend_q  <= 1'b0;
      score_q      <= '0;
      hit_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      plane_x_q    <= plane_x_d;
      dir_right_q  <= dir_right_d;
      gun_x_q      <= gun_x_d;
      bullet_x_q   <= bullet_x_d;
      bullet_y_q   <= bullet_y_d;
      bullet_act_q <= bullet_act_d;
      fire_pend_q  <= fire_pend_d;
      score_q      <= score_d;
      hit_cnt_q    <= hit_cnt_d;
    end
  end

  assign gif.airplane_x    = plane_x_q;
  assign gif.gun_x         = gun_x_q;
  assign gif.bullet_x      = bullet_x_q;
  assign gif.bullet_y      = bullet_y_q;
  assign gif.bullet_active = bullet_act_q;
  assign gif.col           = (state_q == StHit);
  assign gif.finish        = (state_q == StOver);
  assign gif.score         = score_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: a frame-level game model predicts the outputs after every tick and
// queues them; a monitor compares the DUT outputs after each tick edge.
module tb_game_ctrl;

  localparam int MIdle = 0, MPlay = 1, MHit = 2, MOver = 3;

  typedef struct {
    int st; int ax; bit dr; int gx; int bx; int by; bit ba; bit fp; int score; int hc;
  } mdl_t;

  typedef struct {
    int ax; int gx; int bx; int by; bit ba; bit col; bit fin; int score;
  } obs_t;

  logic clk = 1'b0;
  logic reset;
  always #20 clk = ~clk;

  game_if gif ();

  game_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .gif   (gif)
  );

  int   tests = 0;
  int   fails = 0;
  obs_t exp_q[$];
  mdl_t m;
  bit   lv = 1'b0, rv = 1'b0;

  function automatic int clampi(int v, int lo, int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic mdl_t minit();
    mdl_t s;
    s.st = MIdle; s.ax = 0; s.dr = 1'b1; s.gx = 312; s.bx = 0; s.by = 440;
    s.ba = 1'b0; s.fp = 1'b0; s.score = 0; s.hc = 0;
    return s;
  endfunction

  function automatic mdl_t mfire(mdl_t s);
    mdl_t n = s;
    if (s.st == MIdle) n.st = MPlay;
    else if (s.st == MPlay) n.fp = 1'b1;
    return n;
  endfunction

  // One frame of game rules, from the current snapshot to the next one
  function automatic mdl_t mstep(mdl_t s, bit l, bit r);
    mdl_t n = s;
    int   nx;
    if (s.st == MPlay) begin
      if (l != r) n.gx = clampi(s.gx + (r ? 4 : -4), 0, 624);
      if (s.ba && s.bx >= s.ax && s.bx < s.ax + 32 && s.by >= 40 && s.by < 56) begin
        n.ba = 1'b0;
        n.score = (s.score < 31) ? s.score + 1 : 31;
        n.st = MHit;
        n.hc = 0;
      end else begin
        if (s.ba) begin
          if (s.by < 8) n.ba = 1'b0;
          else n.by = s.by - 8;
        end
        nx = s.ax + (s.dr ? 2 : -2);
        if (nx >= 608 || nx <= 0) begin
          n.ax = clampi(nx, 0, 608);
          n.dr = !s.dr;
        end else begin
          n.ax = nx;
        end
      end
      if (s.fp) begin
        n.fp = 1'b0;
        if (!s.ba) begin n.bx = s.gx + 8; n.by = 440; n.ba = 1'b1; end
      end
    end else if (s.st == MHit) begin
      n.hc = s.hc + 1;
      if (n.hc >= 30) begin
        n.hc = 0;
        n.st = (s.score >= 10) ? MOver : MPlay;
      end
    end
    return n;
  endfunction

  function automatic obs_t to_obs(mdl_t s);
    obs_t o;
    o.ax = s.ax; o.gx = s.gx; o.bx = s.bx; o.by = s.by; o.ba = s.ba;
    o.col = (s.st == MHit); o.fin = (s.st == MOver); o.score = s.score;
    return o;
  endfunction

  // Would a fire press now, with no gun motion, end in a hit?
  function automatic bit would_hit(mdl_t s);
    mdl_t t = mfire(s);
    for (int i = 0; i < 70; i++) begin
      t = mstep(t, 1'b0, 1'b0);
      if (t.st == MHit) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Scoreboard monitor
  initial begin
    obs_t e;
    obs_t a;
    forever begin
      @(posedge clk);
      if (gif.tick === 1'b1) begin
        #1;
        tests++;
        a.ax = int'(gif.airplane_x); a.gx = int'(gif.gun_x); a.bx = int'(gif.bullet_x);
        a.by = int'(gif.bullet_y); a.ba = gif.bullet_active; a.col = gif.col;
        a.fin = gif.finish; a.score = int'(gif.score);
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL scoreboard: DUT output at %0t with no expected entry", $time);
        end else begin
          e = exp_q.pop_front();
          if (a != e) begin
            fails++;
            $display("FAIL tick_outputs @%0t: got ax=%0d gx=%0d bx=%0d by=%0d ba=%0b col=%0b fin=%0b score=%0d, expected ax=%0d gx=%0d bx=%0d by=%0d ba=%0b col=%0b fin=%0b score=%0d",
                     $time, a.ax, a.gx, a.bx, a.by, a.ba, a.col, a.fin, a.score,
                     e.ax, e.gx, e.bx, e.by, e.ba, e.col, e.fin, e.score);
          end
        end
      end
    end
  end

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_airplane_x"}, int'(gif.airplane_x), 0);
    chk({tag, "_gun_x"}, int'(gif.gun_x), 312);
    chk({tag, "_bullet_x"}, int'(gif.bullet_x), 0);
    chk({tag, "_bullet_y"}, int'(gif.bullet_y), 440);
    chk({tag, "_bullet_active"}, int'(gif.bullet_active), 0);
    chk({tag, "_col"}, int'(gif.col), 0);
    chk({tag, "_finish"}, int'(gif.finish), 0);
    chk({tag, "_score"}, int'(gif.score), 0);
  endtask

  task automatic do_tick();
    @(negedge clk);
    m = mstep(m, lv, rv);
    exp_q.push_back(to_obs(m));
    gif.tick = 1'b1;
    @(negedge clk);
    gif.tick = 1'b0;
  endtask

  task automatic set_dirs(input bit l, input bit r);
    @(negedge clk);
    gif.bIzq = l;
    gif.bDer = r;
    lv = l;
    rv = r;
    repeat (4) @(negedge clk);
  endtask

  task automatic press_fire();
    @(negedge clk);
    gif.bCen = 1'b1;
    repeat (4) @(negedge clk);
    m = mfire(m);
    gif.bCen = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic press_restart();
    @(negedge clk);
    gif.bR = 1'b1;
    repeat (4) @(negedge clk);
    m = minit();
    gif.bR = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int  n;
    int  budget;
    int  prev_st;
    bit  first_fire;
    bit  first_hit;

    reset = 1'b0;
    gif.tick = 1'b0; gif.bDer = 1'b0; gif.bIzq = 1'b0; gif.bCen = 1'b0; gif.bR = 1'b0;
    m = minit();
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    reset = 1'b1;
    do_tick();  // IDLE: nothing moves

    // Start and glide: five ticks from x=0
    press_fire();
    repeat (5) do_tick();
    chk("start_airplane_x", int'(gif.airplane_x), 10);
    chk("start_gun_x", int'(gif.gun_x), 312);
    chk("start_bullet_active", int'(gif.bullet_active), 0);

    // Gun left into the wall, then right, then both buttons
    set_dirs(1'b1, 1'b0);
    do_tick();
    chk("gun_first_step", int'(gif.gun_x), 308);
    repeat (99) do_tick();
    chk("gun_left_clamp", int'(gif.gun_x), 0);
    set_dirs(1'b0, 1'b1);
    repeat (10) do_tick();
    chk("gun_right_10", int'(gif.gun_x), 40);
    set_dirs(1'b1, 1'b1);
    repeat (5) do_tick();
    chk("gun_both_held", int'(gif.gun_x), 40);
    set_dirs(1'b0, 1'b0);

    // Right-edge bounce
    n = 0;
    while (!(m.ax == 606 && m.dr) && n < 1000) begin do_tick(); n++; end
    chk("reach_606", int'(gif.airplane_x), 606);
    do_tick();
    chk("bounce_608", int'(gif.airplane_x), 608);
    do_tick();
    chk("bounce_back_606", int'(gif.airplane_x), 606);

    // Miss far from the airplane, with a second fire while the bullet flies
    press_fire();
    do_tick();
    chk("miss_spawn_x", int'(gif.bullet_x), 48);
    chk("miss_spawn_y", int'(gif.bullet_y), 440);
    repeat (5) do_tick();
    press_fire();
    n = 0;
    while (m.ba && n < 100) begin do_tick(); n++; end
    repeat (3) do_tick();
    chk("miss_bullet_gone", int'(gif.bullet_active), 0);
    chk("miss_score", int'(gif.score), 0);

    // Centre the gun, then aim and play to a win
    set_dirs(1'b0, 1'b1);
    repeat (68) do_tick();
    set_dirs(1'b0, 1'b0);
    chk("gun_centre", int'(gif.gun_x), 312);
    budget = 9000;
    first_fire = 1'b1;
    first_hit = 1'b1;
    while (m.st != MOver && budget > 0) begin
      prev_st = m.st;
      if (m.st == MPlay && !m.ba && !m.fp && would_hit(m)) begin
        press_fire();
        do_tick();
        if (first_fire) begin
          chk("aim_spawn_x", int'(gif.bullet_x), 320);
          chk("aim_spawn_y", int'(gif.bullet_y), 440);
          chk("aim_spawn_active", int'(gif.bullet_active), 1);
          first_fire = 1'b0;
        end
      end else begin
        do_tick();
      end
      if (prev_st == MPlay && m.st == MHit) begin
        chk("hit_col", int'(gif.col), 1);
        chk("hit_bullet_cleared", int'(gif.bullet_active), 0);
        if (first_hit) begin
          chk("first_hit_score", int'(gif.score), 1);
          n = 0;
          while (gif.col && n < 40) begin do_tick(); n++; end
          chk("hit_duration", n, 30);
          first_hit = 1'b0;
        end
      end
      budget--;
    end
    chk("win_budget_left", int'(budget > 0), 1);
    chk("over_finish", int'(gif.finish), 1);
    chk("over_score", int'(gif.score), 10);
    chk("over_col", int'(gif.col), 0);
    repeat (3) do_tick();
    press_restart();
    do_tick();
    chk_reset_outputs("restart");

    // Randomized play
    for (int i = 0; i < 400; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 6) press_fire();
      else if (r < 10) set_dirs(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else if (r == 99) press_restart();
      do_tick();
    end

    // Asynchronous reset in the middle of play, between clock edges
    set_dirs(1'b0, 1'b1);
    press_fire();
    repeat (12) do_tick();
    @(negedge clk);
    #7;
    reset = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    m = minit();
    set_dirs(1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    do_tick();

    repeat (4) @(negedge clk);
    chk("scoreboard_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
